// File: rtl/chain_score_reduce_if.sv
// -----------------------------------------------------------------------------
// chain_score_reduce_if
// Bundles the three streams that meet at the chaining score reducer:
//   job_*  : job descriptor (valid/ready), one per anchor i
//   sc_*   : per-predecessor score beats (valid only, never back-pressured)
//   res_*  : reduced result toward the chain-storage writer (valid/ready)
// Modports:
//   master : the producer side (issues jobs and scores, consumes results)
//   slave  : the reducer itself
// -----------------------------------------------------------------------------
interface chain_score_reduce_if #(
    parameter int IDX_W = 32,
    parameter int CNT_W = 16
);
    logic             job_valid;
    logic             job_ready;
    logic [CNT_W-1:0] job_nprd;
    logic [31:0]      job_qspan;

    logic             sc_valid;
    logic [31:0]      sc_data;
    logic [31:0]      sc_fj;
    logic [IDX_W-1:0] sc_j;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_f;
    logic [IDX_W-1:0] res_p;

    modport master (
        output job_valid, job_nprd, job_qspan,
        input  job_ready,
        output sc_valid, sc_data, sc_fj, sc_j,
        input  res_valid, res_f, res_p,
        output res_ready
    );

    modport slave (
        input  job_valid, job_nprd, job_qspan,
        output job_ready,
        input  sc_valid, sc_data, sc_fj, sc_j,
        output res_valid, res_f, res_p,
        input  res_ready
    );
endinterface

// File: rtl/chain_score_reduce.sv
// -----------------------------------------------------------------------------
// chain_score_reduce
// Consumer end of the chaining score pipeline. For each anchor i it takes a
// job descriptor, folds the stream of per-predecessor gap scores into
//     f[i] = max(q_span, max_j(f[j] + sc_j))
// and reports the winning predecessor p[i] (all-ones when q_span stands).
//
// Ports:
//   clock      : clock
//   resetn     : asynchronous active-low reset
//   bus        : chain_score_reduce_if.slave (job_*, sc_*, res_* streams)
//   err_stray  : sticky flag, a score beat arrived while not accumulating
//   n_skip     : reject-sentinel beats seen in the current/last job
//
// Optional feature macro:
//   CHAIN_SKIP_STATS_EN : builds the sentinel counter behind n_skip; when
//                         undefined n_skip is tied to zero.
// -----------------------------------------------------------------------------
module chain_score_reduce #(
    parameter int IDX_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                clock,
    input  logic                resetn,
    chain_score_reduce_if.slave bus,
    output logic                err_stray,
    output logic [CNT_W-1:0]    n_skip
);

    // Gap score value the score pipeline uses to say "this predecessor is
    // not chainable"; such beats consume a count but never compete.
    localparam logic [31:0]      SC_REJECT = 32'h8000_0001;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] P_NONE    = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] P_ZERO    = {IDX_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic signed [31:0] best_r;
    logic [IDX_W-1:0] best_p_r;
    logic [CNT_W-1:0] cnt_r;
    logic             job_ready_r;
    logic             res_valid_r;
    logic [31:0]      res_f_r;
    logic [IDX_W-1:0] res_p_r;
    logic             err_stray_r;

    logic               is_reject_s;
    logic signed [31:0] cand_s;
    logic               take_s;
    logic signed [31:0] next_best_s;
    logic [IDX_W-1:0]   next_p_s;

    // Candidate for the current beat and the running max after absorbing it.
    // The add wraps on purpose: the pipeline defines scores modulo 2^32.
    // A strict compare keeps the earlier (nearer) predecessor on ties.
    always_comb begin
        is_reject_s = (bus.sc_data == SC_REJECT);
        cand_s      = $signed(bus.sc_fj) + $signed(bus.sc_data);
        take_s      = 1'b0;
        if (!is_reject_s && (cand_s > best_r)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
        if (take_s) begin
            next_best_s = cand_s;
            next_p_s    = bus.sc_j;
        end else begin
            next_best_s = best_r;
            next_p_s    = best_p_r;
        end
    end

    // Job / accumulate / report state machine with registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            best_r      <= 32'sd0;
            best_p_r    <= P_ZERO;
            cnt_r       <= CNT_ZERO;
            job_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            res_f_r     <= 32'd0;
            res_p_r     <= P_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.job_valid) begin
                        best_r      <= $signed(bus.job_qspan);
                        best_p_r    <= P_NONE;
                        cnt_r       <= bus.job_nprd;
                        job_ready_r <= 1'b0;
                        if (bus.job_nprd != CNT_ZERO) begin
                            state_r <= ST_ACCUM;
                        end else begin
                            // Nothing to absorb: the result is the seed and
                            // is presented straight from the accept edge.
                            state_r     <= ST_DONE;
                            res_valid_r <= 1'b1;
                            res_f_r     <= bus.job_qspan;
                            res_p_r     <= P_NONE;
                        end
                    end else begin
                        job_ready_r <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (bus.sc_valid) begin
                        best_r   <= next_best_s;
                        best_p_r <= next_p_s;
                        cnt_r    <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            // Last beat: publish the post-beat maximum now so
                            // the result is visible the cycle after.
                            state_r     <= ST_DONE;
                            res_valid_r <= 1'b1;
                            res_f_r     <= next_best_s;
                            res_p_r     <= next_p_s;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end else begin
                        state_r <= ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state_r     <= ST_IDLE;
                        res_valid_r <= 1'b0;
                        job_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    job_ready_r <= 1'b1;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for score beats that arrive with no job accumulating.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_stray_r <= 1'b0;
        end else if (bus.sc_valid && (state_r != ST_ACCUM)) begin
            err_stray_r <= 1'b1;
        end else begin
            err_stray_r <= err_stray_r;
        end
    end

`ifdef CHAIN_SKIP_STATS_EN
    logic [CNT_W-1:0] skip_cnt_r;

    // Per-job count of reject-sentinel beats; restarts on every accepted job
    // and holds its final value through the result phase.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            skip_cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_IDLE) && bus.job_valid) begin
            skip_cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_ACCUM) && bus.sc_valid && is_reject_s) begin
            skip_cnt_r <= skip_cnt_r + CNT_ONE;
        end else begin
            skip_cnt_r <= skip_cnt_r;
        end
    end

    assign n_skip = skip_cnt_r;
`else
    assign n_skip = CNT_ZERO;
`endif

    assign bus.job_ready = job_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_f     = res_f_r;
    assign bus.res_p     = res_p_r;
    assign err_stray     = err_stray_r;

endmodule

// File: tb/tb_chain_score_reduce.sv
// -----------------------------------------------------------------------------
// tb_chain_score_reduce
// Directed bench for chain_score_reduce. A reference model computes each
// job's result straight from the max-plus rule; a per-cycle compare process
// checks every presented result against it, and each directed job also pins
// the result against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_chain_score_reduce;

    localparam int          IDX_W = 32;
    localparam int          CNT_W = 16;
    localparam logic [31:0] SENT  = 32'h8000_0001;
    localparam logic [31:0] NONE  = 32'hFFFF_FFFF;

    logic             clock = 1'b0;
    logic             resetn;
    logic             err_stray;
    logic [CNT_W-1:0] n_skip;

    chain_score_reduce_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    chain_score_reduce #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus),
        .err_stray (err_stray),
        .n_skip    (n_skip)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    int               bsc [8];
    int               bfj [8];
    logic [IDX_W-1:0] bj  [8];

    logic [31:0]      exp_f_q [$];
    logic [IDX_W-1:0] exp_p_q [$];
    logic [CNT_W-1:0] exp_s_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: seed with q_span, fold in f[j]+sc_j for every non-sentinel
    // beat, strictly-greater wins so the first (nearest) of equals is kept.
    task automatic model(input int n, input int qspan,
                         output logic [31:0] f, output logic [IDX_W-1:0] p,
                         output logic [CNT_W-1:0] s);
        int best;
        int cand;
        int sk;
        best = qspan;
        p    = NONE;
        sk   = 0;
        for (int i = 0; i < n; i++) begin
            if (bsc[i] == int'(SENT)) begin
                sk++;
            end else begin
                cand = bfj[i] + bsc[i];
                if (cand > best) begin
                    best = cand;
                    p    = bj[i];
                end
            end
        end
        f = best;
`ifdef CHAIN_SKIP_STATS_EN
        s = CNT_W'(sk);
`else
        s = '0;
`endif
    endtask

    // Per-cycle comparison of any presented result against the model queue.
    always @(negedge clock) begin
        if (resetn && bus.res_valid) begin
            if (exp_f_q.size() == 0) begin
                chk("unexpected_result", {31'd0, bus.res_valid}, 32'd0);
            end else begin
                chk("cmp_res_f", bus.res_f, exp_f_q[0]);
                chk("cmp_res_p", bus.res_p, exp_p_q[0]);
                chk("cmp_n_skip", {16'd0, n_skip}, {16'd0, exp_s_q[0]});
                if (bus.res_ready) begin
                    void'(exp_f_q.pop_front());
                    void'(exp_p_q.pop_front());
                    void'(exp_s_q.pop_front());
                end
            end
        end
    end

    task automatic push_expected(input string tag, input int n, input logic [31:0] qspan,
                                 input logic [31:0] lit_f, input logic [31:0] lit_p,
                                 input int lit_skip);
        logic [31:0]      mf;
        logic [IDX_W-1:0] mp;
        logic [CNT_W-1:0] ms;
        model(n, int'(qspan), mf, mp, ms);
        chk({tag, "_model_f"}, mf, lit_f);
        chk({tag, "_model_p"}, mp, lit_p);
`ifdef CHAIN_SKIP_STATS_EN
        chk({tag, "_model_skip"}, {16'd0, ms}, 32'(lit_skip));
`else
        chk({tag, "_model_skip"}, {16'd0, ms}, 32'(lit_skip * 0));
`endif
        exp_f_q.push_back(mf);
        exp_p_q.push_back(mp);
        exp_s_q.push_back(ms);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.job_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("job_ready_timeout", {31'd0, bus.job_ready}, 32'd1);
    endtask

    // Issue one job with the beats in bsc/bfj/bj and res_ready held high.
    task automatic run_job(input string tag, input int n, input logic [31:0] qspan,
                           input logic [31:0] lit_f, input logic [31:0] lit_p,
                           input int lit_skip);
        push_expected(tag, n, qspan, lit_f, lit_p, lit_skip);
        wait_idle();
        @(posedge clock); #1;
        bus.job_valid = 1'b1;
        bus.job_nprd  = CNT_W'(n);
        bus.job_qspan = qspan;
        @(posedge clock); #1;
        bus.job_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.sc_valid = 1'b1;
            bus.sc_data  = bsc[i];
            bus.sc_fj    = bfj[i];
            bus.sc_j     = bj[i];
            @(posedge clock); #1;
            bus.sc_valid = 1'b0;
        end
        @(negedge clock);
        chk({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd1);
        chk({tag, "_res_f"}, bus.res_f, lit_f);
        chk({tag, "_res_p"}, bus.res_p, lit_p);
        @(posedge clock); #1;
        @(negedge clock);
        chk({tag, "_res_dropped"}, {31'd0, bus.res_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        resetn        = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_nprd  = '0;
        bus.job_qspan = '0;
        bus.sc_valid  = 1'b0;
        bus.sc_data   = '0;
        bus.sc_fj     = '0;
        bus.sc_j      = '0;
        bus.res_ready = 1'b1;

        repeat (2) @(negedge clock);
        chk("rst_job_ready", {31'd0, bus.job_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_f", bus.res_f, 32'd0);
        chk("rst_res_p", bus.res_p, 32'd0);
        chk("rst_err_stray", {31'd0, err_stray}, 32'd0);
        chk("rst_n_skip", {16'd0, n_skip}, 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;

        // Basic three-predecessor job.
        bsc[0] = 10; bfj[0] = 20; bj[0] = 32'd7;
        bsc[1] = 12; bfj[1] = 25; bj[1] = 32'd6;
        bsc[2] = 5;  bfj[2] = 10; bj[2] = 32'd5;
        run_job("t1", 3, 32'd15, 32'd37, 32'd6, 0);

        // Sentinel skipped; q_span survives.
        bsc[0] = int'(SENT); bfj[0] = 123; bj[0] = 32'd9;
        bsc[1] = -5;         bfj[1] = 40;  bj[1] = 32'd8;
        run_job("t2", 2, 32'd50, 32'd50, NONE, 1);

        // Tie keeps the nearer predecessor.
        bsc[0] = 5; bfj[0] = 10; bj[0] = 32'd4;
        bsc[1] = 7; bfj[1] = 8;  bj[1] = 32'd3;
        run_job("t3", 2, 32'd0, 32'd15, 32'd4, 0);

        // Wrapping add turns a huge candidate negative.
        bsc[0] = 1; bfj[0] = 32'h7FFF_FFFF; bj[0] = 32'd2;
        run_job("t4", 1, 32'h7FFF_FFF0, 32'h7FFF_FFF0, NONE, 0);

        // Signed compare with all-negative scores and a trailing sentinel.
        bsc[0] = -5;         bfj[0] = -10;  bj[0] = 32'd2;
        bsc[1] = -50;        bfj[1] = -60;  bj[1] = 32'd3;
        bsc[2] = int'(SENT); bfj[2] = 1000; bj[2] = 32'd4;
        run_job("t5", 3, 32'hFFFF_FF9C, 32'hFFFF_FFF1, 32'd2, 1);

        // Zero-predecessor job with the result held off for several cycles.
        push_expected("t6", 0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, NONE, 0);
        wait_idle();
        @(posedge clock); #1;
        bus.res_ready = 1'b0;
        bus.job_valid = 1'b1;
        bus.job_nprd  = '0;
        bus.job_qspan = 32'hFFFF_FFFD;
        @(posedge clock); #1;
        bus.job_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("t6_hold_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("t6_hold_f", bus.res_f, 32'hFFFF_FFFD);
            chk("t6_hold_p", bus.res_p, NONE);
            chk("t6_hold_job_ready", {31'd0, bus.job_ready}, 32'd0);
        end
        @(posedge clock); #1;
        bus.res_ready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("t6_released_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t6_released_job_ready", {31'd0, bus.job_ready}, 32'd1);

        // Stray beat while idle sets the sticky flag and changes nothing else.
        @(posedge clock); #1;
        bus.sc_valid = 1'b1;
        bus.sc_data  = 32'd1000;
        bus.sc_fj    = 32'd1000;
        bus.sc_j     = 32'd77;
        @(posedge clock); #1;
        bus.sc_valid = 1'b0;
        @(negedge clock);
        chk("t7_err_stray", {31'd0, err_stray}, 32'd1);
        bsc[0] = 2; bfj[0] = 3; bj[0] = 32'd11;
        run_job("t7", 1, 32'd1, 32'd5, 32'd11, 0);
        chk("t7_err_sticky", {31'd0, err_stray}, 32'd1);

        // Reset in the middle of accumulation discards the job.
        wait_idle();
        @(posedge clock); #1;
        bus.job_valid = 1'b1;
        bus.job_nprd  = 16'd3;
        bus.job_qspan = 32'd0;
        @(posedge clock); #1;
        bus.job_valid = 1'b0;
        bus.sc_valid  = 1'b1;
        bus.sc_data   = 32'd100;
        bus.sc_fj     = 32'd100;
        bus.sc_j      = 32'd1;
        @(posedge clock); #1;
        bus.sc_valid  = 1'b0;
        resetn        = 1'b0;
        @(negedge clock);
        chk("t8_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t8_rst_err_stray", {31'd0, err_stray}, 32'd0);
        chk("t8_rst_job_ready", {31'd0, bus.job_ready}, 32'd1);
        chk("t8_rst_res_f", bus.res_f, 32'd0);
        chk("t8_rst_res_p", bus.res_p, 32'd0);
        chk("t8_rst_n_skip", {16'd0, n_skip}, 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("t8_no_result", {31'd0, bus.res_valid}, 32'd0);
        end

        // Back-to-back single-beat jobs: one result every three cycles.
        wait_idle();
        @(posedge clock); #1;
        for (int k = 0; k < 4; k++) begin
            bsc[0] = k + 1;
            bfj[0] = 2 * k + 5;
            bj[0]  = 32'(k + 100);
            push_expected("t9", 1, 32'(k * 10),
                          (k == 0) ? 32'd6 : 32'(k * 10),
                          (k == 0) ? 32'd100 : NONE, 0);
            bus.job_valid = 1'b1;
            bus.job_nprd  = 16'd1;
            bus.job_qspan = 32'(k * 10);
            @(negedge clock);
            chk("t9_job_ready", {31'd0, bus.job_ready}, 32'd1);
            @(posedge clock); #1;
            bus.job_valid = 1'b0;
            bus.sc_valid  = 1'b1;
            bus.sc_data   = bsc[0];
            bus.sc_fj     = bfj[0];
            bus.sc_j      = bj[0];
            @(posedge clock); #1;
            bus.sc_valid  = 1'b0;
            @(negedge clock);
            chk("t9_res_valid", {31'd0, bus.res_valid}, 32'd1);
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("t9_drained_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("t9_err_stray", {31'd0, err_stray}, 32'd0);
        chk("all_results_seen", 32'(exp_f_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chain_score_reduce.md
# chain_score_reduce

Consumer end of the chaining score pipeline. For each anchor i it accepts a job descriptor, absorbs the stream of per-predecessor gap scores produced by the score pipeline (one per predecessor j, nearest first), and forms f[i] = max(q_span, max_j(f[j] + sc_j)) with the winning predecessor p[i]. Results go out on a valid/ready port to the chain-storage writer.

## Interface
Parameters:
- IDX_W, 32, width of anchor indices (j, p).
- CNT_W, 16, width of predecessor count.

Ports:
- clock  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  high only in IDLE.
- job_nprd  in  CNT_W  number of scores to follow (0 allowed).
- job_qspan  in  32  initial score (signed).
- sc_valid  in  1  score beat valid; no backpressure, always consumed.
- sc_data  in  32  signed gap score; 0x80000001 = reject sentinel.
- sc_fj  in  32  signed f[j] aligned with sc_data.
- sc_j  in  IDX_W  predecessor index aligned with sc_data.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts.
- res_f  out  32  f[i].
- res_p  out  IDX_W  p[i]; all-ones (-1) if no predecessor won.
- err_stray  out  1  sticky: sc beat arrived outside ACCUM.
- n_skip  out  CNT_W  sentinel count for last job (see Configuration).

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: job_ready=1. On job_valid: load best=job_qspan, best_p=-1, cnt=job_nprd; go ACCUM if job_nprd!=0, else DONE.
- ACCUM: each sc_valid beat: if sc_data==0x80000001 skip (no compare); else cand = sc_fj + sc_data (32-bit two's complement, wraps, no saturation); if cand > best (signed, strict) then best=cand, best_p=sc_j. Ties keep earlier (nearer) predecessor. cnt decrements every beat including sentinels; beat that brings cnt to 0 moves to DONE.
- DONE: res_valid=1, res_f=best, res_p=best_p held stable until res_valid&res_ready, then IDLE.
- sc_valid in IDLE or DONE (including the job-accept cycle): beat ignored, err_stray set; cleared only by reset.
- Beats with no job (cnt already 0) cannot occur in ACCUM by construction.

## Timing
- Reset: state IDLE, job_ready=1, res_valid=0, res_f=0, res_p=0, err_stray=0, n_skip=0, internal best/cnt=0.
- Job accepted at edge k; first score counted at edge k+1 or later.
- Last score beat at edge m -> res_valid=1 from edge m (visible cycle after m), res registered.
- job_nprd=0 accepted at edge k -> res_valid from edge k, res_f=job_qspan, res_p=-1.
- res_ready may be high at res_valid assertion: handshake completes at next edge, job_ready=1 after it; minimum job-to-job spacing = nprd+2 cycles.
- Score input accepts one beat per cycle with no gaps required.
- Reset mid-job: job discarded, no result emitted, all outputs to reset values.

## Configuration
- CHAIN_SKIP_STATS_EN defined: counter of sentinel beats per job, cleared on job accept, n_skip reflects the count for the current/last job and holds through DONE.
- Undefined: counter not built, n_skip tied to 0.

## Test plan
- Job nprd=3, qspan=15; beats (sc,fj,j)=(10,20,7),(12,25,6),(5,10,5) -> res_f=37, res_p=6.
- Job nprd=2, qspan=50; beats (0x80000001,*,9),(-5,40,8) -> res_f=50, res_p=-1; n_skip=1 with macro, 0 without.
- Tie: nprd=2, qspan=0; beats (5,10,4),(7,8,3) -> res_f=15, res_p=4.
- nprd=0, qspan=-3 -> res_valid next cycle, res_f=-3, res_p=0xFFFFFFFF; res_ready held low 4 cycles -> outputs stable, job_ready=0 throughout.
- sc_valid pulse while IDLE -> err_stray=1, next job result unaffected; assert resetn low mid-ACCUM -> no res_valid, err_stray=0.
- Back-to-back jobs nprd=1 with res_ready=1 and continuous beats -> one result every 3 cycles, values correct.
